// File: rtl/cipher_frame_loader.sv
// cipher_frame_loader: gathers a key and a message from a byte stream and
// presents them as one stable flattened frame until the consumer takes it.
module cipher_frame_loader #(
  parameter int unsigned MSG_LEN = 6,
  parameter int unsigned SEC_LEN = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   rekey,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   key_valid,
  output logic [8*MSG_LEN-1:0]   text_flat,
  output logic [8*SEC_LEN-1:0]   secret_flat
);

  localparam int unsigned MAX_LEN = (MSG_LEN > SEC_LEN) ? MSG_LEN : SEC_LEN;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    MSG  = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        in_ready_q, in_ready_d;
  logic                        frame_valid_q, frame_valid_d;
  logic                        key_valid_q, key_valid_d;
  logic                        rekey_pend_q, rekey_pend_d;
  logic [MSG_LEN-1:0][7:0]     text_q, text_d;
  logic [SEC_LEN-1:0][7:0]     secret_q, secret_d;

  logic xfer;
  logic key_last;
  logic msg_last;
  logic rekey_now;

  assign xfer      = in_valid && in_ready_q;
  assign key_last  = (cnt_q == CNT_W'(SEC_LEN - 1));
  assign msg_last  = (cnt_q == CNT_W'(MSG_LEN - 1));
  assign rekey_now = rekey_pend_q || rekey;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; phases advance only on accepted bytes or a frame handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = KEY;
      KEY:     if (xfer && key_last) state_d = MSG;
      MSG:     if (xfer && msg_last) state_d = HOLD;
      HOLD:    if (frame_ready) state_d = rekey_now ? KEY : MSG;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; buffers only change on accepted bytes
  always_comb begin
    cnt_d         = cnt_q;
    in_ready_d    = in_ready_q;
    frame_valid_d = frame_valid_q;
    key_valid_d   = key_valid_q;
    rekey_pend_d  = rekey_pend_q;
    text_d        = text_q;
    secret_d      = secret_q;
    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        key_valid_d = 1'b0;
      end
      KEY: begin
        if (xfer) begin
          for (int unsigned i = 0; i < SEC_LEN; i++) begin
            if (cnt_q == CNT_W'(i)) secret_d[i] = in_data;
          end
          if (key_last) begin
            cnt_d       = '0;
            key_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      MSG: begin
        if (rekey) rekey_pend_d = 1'b1;
        if (xfer) begin
          for (int unsigned i = 0; i < MSG_LEN; i++) begin
            if (cnt_q == CNT_W'(i)) text_d[i] = in_data;
          end
          if (msg_last) begin
            cnt_d         = '0;
            in_ready_d    = 1'b0;
            frame_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (rekey) rekey_pend_d = 1'b1;
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          in_ready_d    = 1'b1;
          if (rekey_now) begin
            key_valid_d  = 1'b0;
            rekey_pend_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, counter and buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      key_valid_q   <= 1'b0;
      rekey_pend_q  <= 1'b0;
      text_q        <= '0;
      secret_q      <= '0;
    end else begin
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
      key_valid_q   <= key_valid_d;
      rekey_pend_q  <= rekey_pend_d;
      text_q        <= text_d;
      secret_q      <= secret_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign frame_valid = frame_valid_q;
  assign key_valid   = key_valid_q;
  assign text_flat   = text_q;
  assign secret_flat = secret_q;

endmodule

// File: tb/tb_cipher_frame_loader.sv
// Directed bench for cipher_frame_loader: a cycle table for the main frame
// flow plus hand-written bubble and mid-frame reset sequences.
module tb_cipher_frame_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        rekey;
  logic        frame_valid;
  logic        frame_ready;
  logic        key_valid;
  logic [47:0] text_flat;
  logic [23:0] secret_flat;

  int n_cmp = 0;
  int n_err = 0;

  cipher_frame_loader #(.MSG_LEN(6), .SEC_LEN(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .rekey       (rekey),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .key_valid   (key_valid),
    .text_flat   (text_flat),
    .secret_flat (secret_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rk;
    logic        fr;
    logic        e_ir;
    logic        e_fv;
    logic        e_kv;
    logic        chk;
    logic [47:0] e_txt;
    logic [23:0] e_sec;
  } vec_t;

  vec_t tbl[$];

  localparam logic [23:0] KEY_KEY = 24'h59454B;
  localparam logic [23:0] KEY_XYZ = 24'h5A5958;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_row(input logic v, input logic [7:0] d, input logic rk, input logic fr,
                         input logic ir, input logic fv, input logic kv,
                         input logic c = 1'b0, input logic [47:0] t = '0,
                         input logic [23:0] s = '0);
    vec_t e;
    e.v = v; e.d = d; e.rk = rk; e.fr = fr;
    e.e_ir = ir; e.e_fv = fv; e.e_kv = kv;
    e.chk = c; e.e_txt = t; e.e_sec = s;
    tbl.push_back(e);
  endtask

  // One accepted byte per row, same expected flags for every row
  task automatic add_str(input string s, input logic fr, input logic ir,
                         input logic fv, input logic kv);
    for (int i = 0; i < s.len(); i++) add_row(1'b1, s[i], 1'b0, fr, ir, fv, kv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  bytes [6];
    logic [47:0] exp_txt;
    int          idx;
    int          cyc;
    logic        acc;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; rekey = 1'b0; frame_ready = 1'b0;

    // Frame 1 "KEY"+"HELLOW", held 5 cycles with a pending byte offered
    add_row(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_str("KE", 1'b1, 1'b1, 1'b0, 1'b0);
    add_str("Y", 1'b1, 1'b1, 1'b0, 1'b1);
    add_str("HELLO", 1'b1, 1'b1, 1'b0, 1'b1);
    add_row(1'b1, "W", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 48'h574F4C4C4548, KEY_KEY);
    for (int i = 0; i < 5; i++)
      add_row(1'b1, "Z", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 48'h574F4C4C4548, KEY_KEY);
    add_row(1'b1, "Z", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    // Frame 2 "ABCDEF" reuses the key
    add_str("ABCDE", 1'b1, 1'b1, 1'b0, 1'b1);
    add_row(1'b1, "F", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 48'h464544434241, KEY_KEY);
    add_row(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    // Frame 3 "123456" with rekey on the 3rd byte, then new key "XYZ"
    add_str("12", 1'b1, 1'b1, 1'b0, 1'b1);
    add_row(1'b1, "3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add_str("45", 1'b1, 1'b1, 1'b0, 1'b1);
    add_row(1'b1, "6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 48'h363534333231, KEY_KEY);
    add_row(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_str("XY", 1'b1, 1'b1, 1'b0, 1'b0);
    add_str("Z", 1'b1, 1'b1, 1'b0, 1'b1);
    add_str("abcde", 1'b1, 1'b1, 1'b0, 1'b1);
    add_row(1'b1, "f", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 48'h666564636261, KEY_XYZ);
    // rekey coincident with the handshake acts at once; rekey in KEY is ignored
    add_row(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_row(1'b1, "K", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_str("E", 1'b0, 1'b1, 1'b0, 1'b0);
    add_row(1'b1, "Y", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 48'h666564636261, KEY_KEY);

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset frame_valid", 64'(frame_valid), 64'd0);
    chk("reset key_valid", 64'(key_valid), 64'd0);
    chk("reset text_flat", 64'(text_flat), 64'd0);
    chk("reset secret_flat", 64'(secret_flat), 64'd0);
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      in_valid = tbl[r].v; in_data = tbl[r].d; rekey = tbl[r].rk; frame_ready = tbl[r].fr;
      tick();
      chk($sformatf("row%0d in_ready", r), 64'(in_ready), 64'(tbl[r].e_ir));
      chk($sformatf("row%0d frame_valid", r), 64'(frame_valid), 64'(tbl[r].e_fv));
      chk($sformatf("row%0d key_valid", r), 64'(key_valid), 64'(tbl[r].e_kv));
      if (tbl[r].chk) begin
        chk($sformatf("row%0d text_flat", r), 64'(text_flat), 64'(tbl[r].e_txt));
        chk($sformatf("row%0d secret_flat", r), 64'(secret_flat), 64'(tbl[r].e_sec));
      end
    end
    in_valid = 1'b0; rekey = 1'b0; frame_ready = 1'b0;

    // Three frames with random input bubbles; key "KEY" stays loaded
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 6; i++) begin
        bytes[i] = 8'($urandom_range(32, 126));
        exp_txt[i*8 +: 8] = bytes[i];
      end
      idx = 0;
      cyc = 0;
      while (idx < 6 && cyc < 200) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = bytes[idx];
        acc = in_valid && in_ready;
        tick();
        if (acc) idx++;
        cyc++;
      end
      in_valid = 1'b0;
      chk($sformatf("bub%0d bytes accepted", f), 64'(idx), 64'd6);
      chk($sformatf("bub%0d frame_valid", f), 64'(frame_valid), 64'd1);
      chk($sformatf("bub%0d in_ready", f), 64'(in_ready), 64'd0);
      chk($sformatf("bub%0d text_flat", f), 64'(text_flat), 64'(exp_txt));
      chk($sformatf("bub%0d secret_flat", f), 64'(secret_flat), 64'(KEY_KEY));
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      chk($sformatf("bub%0d hs frame_valid", f), 64'(frame_valid), 64'd0);
      chk($sformatf("bub%0d hs in_ready", f), 64'(in_ready), 64'd1);
      chk($sformatf("bub%0d hs key_valid", f), 64'(key_valid), 64'd1);
    end

    // Reset asserted while the 4th message byte is offered
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h61 + 8'(i);
      tick();
    end
    in_data = 8'h64;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 64'(in_ready), 64'd0);
    chk("midrst frame_valid", 64'(frame_valid), 64'd0);
    chk("midrst key_valid", 64'(key_valid), 64'd0);
    chk("midrst text_flat", 64'(text_flat), 64'd0);
    chk("midrst secret_flat", 64'(secret_flat), 64'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst in_ready", 64'(in_ready), 64'd1);
    chk("postrst key_valid", 64'(key_valid), 64'd0);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 8'h50 + 8'(i);
      tick();
      chk($sformatf("postrst b%0d key_valid", i), 64'(key_valid), 64'(i >= 2));
      chk($sformatf("postrst b%0d frame_valid", i), 64'(frame_valid), 64'(i == 8));
    end
    in_valid = 1'b0;
    chk("postrst secret_flat", 64'(secret_flat), 64'h525150);
    chk("postrst text_flat", 64'(text_flat), 64'h585756555453);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("postrst hs frame_valid", 64'(frame_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
